// File: rtl/serv_rst_pkg.sv
// Shared types for the SERV reset sequencer: sequencer states and the
// encodings of the recorded reset cause.
package serv_rst_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_INIT      = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam logic [1:0] CAUSE_POR     = 2'b00;
  localparam logic [1:0] CAUSE_LOCK    = 2'b01;
  localparam logic [1:0] CAUSE_SW      = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

endpackage

// File: rtl/serv_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, cleared
// asynchronously so the synchronized value reads 0 throughout reset.
module serv_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], i_d};

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/serv_rst_seq.sv
// Staged reset sequencer: memories released after stable PLL lock, then an
// init handshake, then the core; the cause of the last reset is kept.
module serv_rst_seq
  import serv_rst_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_sw_rst,
  input  logic       i_init_done,
  output logic       o_rst_mem,
  output logic       o_init_req,
  output logic       o_rst_core,
  output logic       o_ready,
  output logic [1:0] o_cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > INIT_TIMEOUT) ? HOLD_CYCLES : INIT_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam bit               TIMEOUT_EN = (INIT_TIMEOUT != 0);

  logic             lock_s;
  logic             lock_lost;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             rst_mem_q, rst_mem_d;
  logic             init_req_q, init_req_d;
  logic             rst_core_q, rst_core_d;
  logic             ready_q, ready_d;

  serv_sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (lock_s)
  );

  assign lock_lost = !lock_s && (state_q == ST_HOLD || state_q == ST_INIT || state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_RESET:     state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_s) state_d = ST_HOLD;
      ST_HOLD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == HOLD_LAST) state_d = ST_INIT;
      end
      ST_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (TIMEOUT_EN && cnt_q == INIT_LAST) begin
          state_d = ST_WAIT_LOCK;
          cause_d = CAUSE_TIMEOUT;
        end else if (i_init_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_sw_rst) begin
          state_d = ST_WAIT_LOCK;
          cause_d = CAUSE_SW;
        end
      end
      default: state_d = ST_RESET;
    endcase
    // Lock loss overrides every other event in the same cycle.
    if (lock_lost) begin
      state_d = ST_WAIT_LOCK;
      cause_d = CAUSE_LOCK;
    end
    if (state_d != state_q) cnt_d = '0;

    rst_mem_d  = 1'b1;
    init_req_d = 1'b0;
    rst_core_d = 1'b1;
    ready_d    = 1'b0;
    case (state_d)
      ST_INIT: begin
        rst_mem_d  = 1'b0;
        init_req_d = 1'b1;
      end
      ST_RUN: begin
        rst_mem_d  = 1'b0;
        rst_core_d = 1'b0;
        ready_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      cause_q    <= CAUSE_POR;
      rst_mem_q  <= 1'b1;
      init_req_q <= 1'b0;
      rst_core_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      rst_mem_q  <= rst_mem_d;
      init_req_q <= init_req_d;
      rst_core_q <= rst_core_d;
      ready_q    <= ready_d;
    end
  end

  assign o_rst_mem  = rst_mem_q;
  assign o_init_req = init_req_q;
  assign o_rst_core = rst_core_q;
  assign o_ready    = ready_q;
  assign o_cause    = cause_q;

endmodule

// File: tb/tb_serv_rst_seq.sv
// Bench for serv_rst_seq: fixed vector table, hand-written corner sequences
// and random stimulus, all compared against a phase-level reference model.
module tb_serv_rst_seq;

  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int TO   = 8;

  // reference-model phases
  localparam int P_RESET = 0;
  localparam int P_WAIT  = 1;
  localparam int P_HOLD  = 2;
  localparam int P_INIT  = 3;
  localparam int P_RUN   = 4;

  logic       clk;
  logic       rst;
  logic       pll;
  logic       sw;
  logic       done;
  logic       o_rst_mem, o_init_req, o_rst_core, o_ready;
  logic [1:0] o_cause;

  int n_cmp;
  int n_bad;

  int         m_phase;
  int         m_cnt;
  logic [1:0] m_cause;
  logic [3:0] m_hist;

  typedef struct {
    int         n;
    logic       pll;
    logic       sw;
    logic       done;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [9];

  serv_rst_seq #(
    .SYNC_STAGES  (SYNC),
    .HOLD_CYCLES  (HOLD),
    .INIT_TIMEOUT (TO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pll_locked (pll),
    .i_sw_rst     (sw),
    .i_init_done  (done),
    .o_rst_mem    (o_rst_mem),
    .o_init_req   (o_init_req),
    .o_rst_core   (o_rst_core),
    .o_ready      (o_ready),
    .o_cause      (o_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] dut_out();
    return {o_rst_mem, o_init_req, o_rst_core, o_ready, o_cause};
  endfunction

  // {rst_mem, init_req, rst_core, ready, cause}
  function automatic logic [5:0] model_out();
    logic [3:0] ctl;
    case (m_phase)
      P_INIT:  ctl = 4'b0110;
      P_RUN:   ctl = 4'b0001;
      default: ctl = 4'b1010;
    endcase
    return {ctl, m_cause};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RESET;
    m_cnt   = 0;
    m_cause = 2'b00;
    m_hist  = '0;
  endtask

  task automatic go_wait(input logic [1:0] cause);
    m_phase = P_WAIT;
    m_cause = cause;
  endtask

  // One clock edge of the reference model, using the inputs held before it.
  task automatic model_step();
    logic ls;
    if (!rst) begin
      ls = m_hist[SYNC-1];
      case (m_phase)
        P_RESET: m_phase = P_WAIT;
        P_WAIT: begin
          if (ls) begin m_phase = P_HOLD; m_cnt = 0; end
        end
        P_HOLD: begin
          if (!ls) go_wait(2'b01);
          else begin
            m_cnt++;
            if (m_cnt == HOLD) begin m_phase = P_INIT; m_cnt = 0; end
          end
        end
        P_INIT: begin
          if (!ls) go_wait(2'b01);
          else begin
            m_cnt++;
            if (TO != 0 && m_cnt == TO) go_wait(2'b11);
            else if (done) m_phase = P_RUN;
          end
        end
        default: begin
          if (!ls) go_wait(2'b01);
          else if (sw) go_wait(2'b10);
        end
      endcase
      m_hist = {m_hist[2:0], pll};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out(), model_out());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_state", dut_out(), 6'b101000);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; pll = 1'b1; sw = 1'b0; done = 1'b0;
    model_reset();

    tbl[0] = '{18, 1'b1, 1'b0, 1'b0, 6'b101000};
    tbl[1] = '{ 1, 1'b1, 1'b0, 1'b0, 6'b011000};
    tbl[2] = '{ 5, 1'b1, 1'b0, 1'b0, 6'b011000};
    tbl[3] = '{ 1, 1'b1, 1'b0, 1'b1, 6'b000100};
    tbl[4] = '{ 3, 1'b1, 1'b0, 1'b0, 6'b000100};
    tbl[5] = '{ 1, 1'b1, 1'b1, 1'b0, 6'b101010};
    tbl[6] = '{ 1, 1'b1, 1'b0, 1'b0, 6'b101010};
    tbl[7] = '{15, 1'b1, 1'b0, 1'b0, 6'b101010};
    tbl[8] = '{ 1, 1'b1, 1'b0, 1'b0, 6'b011010};

    // power-on, soft reset and re-sequence
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pll  = tbl[i].pll;
      sw   = tbl[i].sw;
      done = tbl[i].done;
      for (int k = 0; k < tbl[i].n; k++) tick();
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // asynchronous reset in RUN, between clock edges
    done = 1'b1;
    tick();
    check("run_before_async", dut_out(), 6'b000110);
    done = 1'b0;
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_core", {5'b0, o_rst_core}, 6'b000001);
    check("async_ready", {5'b0, o_ready}, 6'b000000);
    check("async_cause", {4'b0, o_cause}, 6'b000000);
    tick();
    rst = 1'b0;

    // one-cycle lock drop during HOLD
    do_reset();
    repeat (13) tick();
    pll = 1'b0;
    tick();
    pll = 1'b1;
    tick();
    tick();
    check("lockdrop_wait", dut_out(), 6'b101001);
    repeat (16) tick();
    check("relock_hold16", dut_out(), 6'b101001);
    tick();
    check("relock_init", dut_out(), 6'b011001);

    // init timeout and automatic retry
    do_reset();
    repeat (26) tick();
    check("to_last_init", dut_out(), 6'b011000);
    tick();
    check("to_fire", dut_out(), 6'b101011);
    repeat (17) tick();
    check("to_retry_init", dut_out(), 6'b011011);

    // lock loss and init done in the same INIT cycle
    do_reset();
    repeat (19) tick();
    pll = 1'b0;
    tick();
    tick();
    check("both_still_init", dut_out(), 6'b011000);
    done = 1'b1;
    tick();
    check("both_lock_wins", dut_out(), 6'b101001);
    done = 1'b0;
    pll  = 1'b1;

    // random stimulus against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) pll = ~pll;
      else if (!pll && $urandom_range(0, 3) == 0) pll = 1'b1;
      sw   = ($urandom_range(0, 29) == 0);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
